// File: rtl/reg_trigger_sequencer_pkg.sv
// ============================================================================
// reg_trigger_sequencer_pkg
// Shared register addresses, layout constants and FSM encoding.
// Revision: 1.0
// ============================================================================
`default_nettype none

package reg_trigger_sequencer_pkg;

    localparam int c_addr_cfg      = 52;
    localparam int c_addr_stage    = 53;
    localparam int c_addr_status   = 54;

    localparam int c_cfg_bytes     = 4;
    localparam int c_stage_bytes   = 4;
    localparam int c_status_bytes  = 2;

    localparam int c_cfg_en_bit    = 0;
    localparam int c_cfg_rearm_bit = 1;
    localparam int c_cfg_last_lsb  = 4;
    localparam int c_cfg_last_w    = 3;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_STAGE = 2'd1,
        ST_PULSE      = 2'd2,
        ST_DONE       = 2'd3
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/reg_trigger_sequencer_sync.sv
// ============================================================================
// trigseq_sync
// Two-flop synchroniser on the target IO lines plus masked stage comparator.
// Revision: 1.0
// ============================================================================
`default_nettype none

module trigseq_sync #(
    parameter int NUM_IO = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_IO-1:0] i_trig,
    input  logic [NUM_IO-1:0] i_mask,
    input  logic [NUM_IO-1:0] i_value,
    output logic              o_cond
);

    logic [NUM_IO-1:0] r_meta;
    logic [NUM_IO-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_trig;
            r_sync <= r_meta;
        end
    end

    // A zero mask compares no bits, so the stage condition is constantly true.
    assign o_cond = ((r_sync ^ i_value) & i_mask) == '0;

endmodule

`default_nettype wire

// File: rtl/reg_trigger_sequencer.sv
// ============================================================================
// reg_trigger_sequencer
// Multi-stage masked-pattern trigger on the 8-bit register bus.
// Revision: 1.0
// ============================================================================
`default_nettype none

module reg_trigger_sequencer
    import reg_trigger_sequencer_pkg::*;
#(
    parameter int NUM_IO      = 4,
    parameter int NUM_STAGES  = 4,
    parameter int CNT_WIDTH   = 16,
    parameter int ADDR_CFG    = c_addr_cfg,
    parameter int ADDR_STAGE  = c_addr_stage,
    parameter int ADDR_STATUS = c_addr_status
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic [5:0]        reg_address,
    input  logic [15:0]       reg_bytecnt,
    input  logic [7:0]        reg_datai,
    output logic [7:0]        reg_datao,
    input  logic [15:0]       reg_size,
    input  logic              reg_read,
    input  logic              reg_write,
    input  logic              reg_addrvalid,
    input  logic [5:0]        reg_hypaddress,
    output logic [15:0]       reg_hyplen,
    input  logic [NUM_IO-1:0] trig_in,
    output logic              trig_out,
    output logic              armed_o
);

    localparam int         c_tbl_bytes = NUM_STAGES * c_stage_bytes;
    localparam int         c_sidx_w    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [2:0] c_max_stage = 3'(NUM_STAGES - 1);

    logic [7:0]           r_cfg_ctrl;
    logic [7:0]           r_cfg_width;
    logic [7:0]           r_mask   [NUM_STAGES];
    logic [7:0]           r_value  [NUM_STAGES];
    logic [7:0]           r_win_lo [NUM_STAGES];
    logic [7:0]           r_win_hi [NUM_STAGES];

    state_t               r_state,      w_state_nxt;
    logic [2:0]           r_stage,      w_stage_nxt;
    logic [CNT_WIDTH-1:0] r_timer,      w_timer_nxt;
    logic                 r_seen_false, w_seen_nxt;
    logic [7:0]           r_pulse_cnt,  w_pulse_cnt_nxt;
    logic                 r_trig,       w_trig_nxt;
    logic                 r_sticky;
    logic [7:0]           r_abort_cnt;
    logic                 w_sticky_set;
    logic                 w_abort_inc;

    logic                 w_wr, w_rd;
    logic                 w_hit_cfg, w_hit_stage, w_hit_status;
    logic                 w_cfg_wr0, w_arm_req, w_disarm_req, w_status_wr;
    logic                 w_tbl_in_range;
    logic [c_sidx_w-1:0]  w_tbl_sel;
    logic [1:0]           w_tbl_field;
    logic [c_sidx_w-1:0]  w_cur;
    logic [15:0]          w_window;
    logic [2:0]           w_last_raw, w_last;
    logic [7:0]           w_width;
    logic                 w_rearm;
    logic                 w_cond;
    logic [7:0]           w_rdata;
    logic [15:0]          w_hyplen;
    logic                 w_unused_size;

    assign w_wr         = reg_write & reg_addrvalid;
    assign w_rd         = reg_read & reg_addrvalid;
    assign w_hit_cfg    = (reg_address == 6'(ADDR_CFG));
    assign w_hit_stage  = (reg_address == 6'(ADDR_STAGE));
    assign w_hit_status = (reg_address == 6'(ADDR_STATUS));

    assign w_cfg_wr0    = w_wr & w_hit_cfg & (reg_bytecnt == 16'd0);
    assign w_arm_req    = w_cfg_wr0 &  reg_datai[c_cfg_en_bit];
    assign w_disarm_req = w_cfg_wr0 & ~reg_datai[c_cfg_en_bit];
    assign w_status_wr  = w_wr & w_hit_status;

    assign w_tbl_in_range = (reg_bytecnt < 16'(c_tbl_bytes));
    assign w_tbl_sel      = reg_bytecnt[c_sidx_w+1:2];
    assign w_tbl_field    = reg_bytecnt[1:0];

    assign w_cur      = r_stage[c_sidx_w-1:0];
    assign w_window   = {r_win_hi[w_cur], r_win_lo[w_cur]};
    assign w_last_raw = r_cfg_ctrl[c_cfg_last_lsb +: c_cfg_last_w];
    assign w_last     = (w_last_raw > c_max_stage) ? c_max_stage : w_last_raw;
    assign w_width    = (r_cfg_width == 8'd0) ? 8'd1 : r_cfg_width;
    assign w_rearm    = r_cfg_ctrl[c_cfg_rearm_bit];

    assign w_unused_size = ^reg_size;

    trigseq_sync #(
        .NUM_IO (NUM_IO)
    ) u_sync (
        .clk     (clk),
        .rst     (reset_i),
        .i_trig  (trig_in),
        .i_mask  (r_mask[w_cur][NUM_IO-1:0]),
        .i_value (r_value[w_cur][NUM_IO-1:0]),
        .o_cond  (w_cond)
    );

    // Register file: stage table writes land immediately, even while armed.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_cfg_ctrl  <= '0;
            r_cfg_width <= '0;
            for (int s = 0; s < NUM_STAGES; s++) begin
                r_mask[s]   <= '0;
                r_value[s]  <= '0;
                r_win_lo[s] <= '0;
                r_win_hi[s] <= '0;
            end
        end else if (w_wr) begin
            if (w_hit_cfg) begin
                if (reg_bytecnt == 16'd0) r_cfg_ctrl  <= reg_datai;
                if (reg_bytecnt == 16'd1) r_cfg_width <= reg_datai;
            end
            if (w_hit_stage && w_tbl_in_range) begin
                case (w_tbl_field)
                    2'd0:    r_mask[w_tbl_sel]   <= reg_datai;
                    2'd1:    r_value[w_tbl_sel]  <= reg_datai;
                    2'd2:    r_win_lo[w_tbl_sel] <= reg_datai;
                    default: r_win_hi[w_tbl_sel] <= reg_datai;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_sticky    <= 1'b0;
            r_abort_cnt <= '0;
        end else if (w_status_wr) begin
            r_sticky    <= 1'b0;
            r_abort_cnt <= '0;
        end else begin
            if (w_sticky_set) r_sticky    <= 1'b1;
            if (w_abort_inc)  r_abort_cnt <= sat_inc8(r_abort_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_state      <= ST_IDLE;
            r_stage      <= '0;
            r_timer      <= '0;
            r_seen_false <= 1'b0;
            r_pulse_cnt  <= '0;
            r_trig       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_stage      <= w_stage_nxt;
            r_timer      <= w_timer_nxt;
            r_seen_false <= w_seen_nxt;
            r_pulse_cnt  <= w_pulse_cnt_nxt;
            r_trig       <= w_trig_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_stage_nxt     = r_stage;
        w_timer_nxt     = r_timer;
        w_seen_nxt      = r_seen_false;
        w_pulse_cnt_nxt = r_pulse_cnt;
        w_trig_nxt      = r_trig;
        w_sticky_set    = 1'b0;
        w_abort_inc     = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_arm_req) begin
                    w_state_nxt = ST_WAIT_STAGE;
                    w_stage_nxt = '0;
                    w_timer_nxt = '0;
                    w_seen_nxt  = 1'b0;
                end
            end
            ST_WAIT_STAGE: begin
                if ((r_stage != 3'd0) && (r_timer != '1))
                    w_timer_nxt = r_timer + 1'b1;
                if (!w_cond)
                    w_seen_nxt = 1'b1;
                // seen_false keeps one held level from satisfying consecutive stages.
                if (w_cond && r_seen_false) begin
                    if (r_stage >= w_last) begin
                        w_state_nxt     = ST_PULSE;
                        w_pulse_cnt_nxt = w_width - 8'd1;
                        w_trig_nxt      = 1'b1;
                        w_sticky_set    = 1'b1;
                    end else begin
                        w_stage_nxt = r_stage + 3'd1;
                        w_timer_nxt = '0;
                        w_seen_nxt  = 1'b0;
                    end
                end else if ((r_stage != 3'd0) && (w_window != 16'd0) &&
                             (r_timer == CNT_WIDTH'(w_window))) begin
                    w_stage_nxt = '0;
                    w_timer_nxt = '0;
                    w_seen_nxt  = 1'b0;
                    w_abort_inc = 1'b1;
                end
            end
            ST_PULSE: begin
                if (r_pulse_cnt == 8'd0) begin
                    w_trig_nxt = 1'b0;
                    if (w_rearm) begin
                        w_state_nxt = ST_WAIT_STAGE;
                        w_stage_nxt = '0;
                        w_timer_nxt = '0;
                        w_seen_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end else begin
                    w_pulse_cnt_nxt = r_pulse_cnt - 8'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_disarm_req) begin
            w_state_nxt     = ST_IDLE;
            w_stage_nxt     = '0;
            w_timer_nxt     = '0;
            w_seen_nxt      = 1'b0;
            w_pulse_cnt_nxt = '0;
            w_trig_nxt      = 1'b0;
        end
    end

    always_comb begin
        w_rdata = 8'h00;
        if (w_rd) begin
            if (w_hit_cfg) begin
                if (reg_bytecnt == 16'd0) w_rdata = r_cfg_ctrl;
                if (reg_bytecnt == 16'd1) w_rdata = r_cfg_width;
            end else if (w_hit_stage && w_tbl_in_range) begin
                case (w_tbl_field)
                    2'd0:    w_rdata = r_mask[w_tbl_sel];
                    2'd1:    w_rdata = r_value[w_tbl_sel];
                    2'd2:    w_rdata = r_win_lo[w_tbl_sel];
                    default: w_rdata = r_win_hi[w_tbl_sel];
                endcase
            end else if (w_hit_status) begin
                if (reg_bytecnt == 16'd0) w_rdata = {r_sticky, 4'b0000, r_stage};
                if (reg_bytecnt == 16'd1) w_rdata = r_abort_cnt;
            end
        end
    end

    always_comb begin
        w_hyplen = 16'd0;
        if (reg_hypaddress == 6'(ADDR_CFG))    w_hyplen = 16'(c_cfg_bytes);
        if (reg_hypaddress == 6'(ADDR_STAGE))  w_hyplen = 16'(c_tbl_bytes);
        if (reg_hypaddress == 6'(ADDR_STATUS)) w_hyplen = 16'(c_status_bytes);
    end

    assign reg_datao  = w_rdata;
    assign reg_hyplen = w_hyplen;
    assign trig_out   = r_trig;
    assign armed_o    = (r_state == ST_WAIT_STAGE);

endmodule

`default_nettype wire

// File: tb/tb_reg_trigger_sequencer.sv
// ============================================================================
// tb_reg_trigger_sequencer
// Scoreboard bench: directed stimulus queues expectations, monitors compare.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_reg_trigger_sequencer;

    localparam logic [5:0] A_CFG = 6'd52;
    localparam logic [5:0] A_STG = 6'd53;
    localparam logic [5:0] A_STS = 6'd54;
    localparam int K_DATA  = 0;
    localparam int K_HYP   = 1;
    localparam int K_ARMED = 2;
    localparam int K_TRIG  = 3;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [5:0]  reg_address = '0;
    logic [15:0] reg_bytecnt = '0;
    logic [7:0]  reg_datai = '0;
    logic [7:0]  reg_datao;
    logic [15:0] reg_size = '0;
    logic        reg_read = 1'b0;
    logic        reg_write = 1'b0;
    logic        reg_addrvalid = 1'b0;
    logic [5:0]  reg_hypaddress = '0;
    logic [15:0] reg_hyplen;
    logic [3:0]  trig_in = '0;
    logic        trig_out;
    logic        armed_o;

    reg_trigger_sequencer dut (
        .clk            (clk),
        .reset_i        (reset_i),
        .reg_address    (reg_address),
        .reg_bytecnt    (reg_bytecnt),
        .reg_datai      (reg_datai),
        .reg_datao      (reg_datao),
        .reg_size       (reg_size),
        .reg_read       (reg_read),
        .reg_write      (reg_write),
        .reg_addrvalid  (reg_addrvalid),
        .reg_hypaddress (reg_hypaddress),
        .reg_hyplen     (reg_hyplen),
        .trig_in        (trig_in),
        .trig_out       (trig_out),
        .armed_o        (armed_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int kind; string name; logic [15:0] exp; } chk_t;
    typedef struct { int start; int len; string name; } pulse_t;
    chk_t   rq[$];
    pulse_t pq[$];
    int     n_checks = 0;
    int     n_fail = 0;
    bit     chk_stb = 1'b0;

    // Level/read monitor
    always @(negedge clk) begin
        chk_t        e;
        logic [15:0] got;
        if (chk_stb && rq.size() > 0) begin
            e = rq.pop_front();
            case (e.kind)
                K_DATA:  got = {8'h00, reg_datao};
                K_HYP:   got = reg_hyplen;
                K_ARMED: got = {15'd0, armed_o};
                default: got = {15'd0, trig_out};
            endcase
            n_checks++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, got, e.exp);
            end
        end
    end

    // Pulse monitor: measures each trig_out pulse as (start cycle, length)
    bit prev_trig = 1'b0;
    int p_start = 0;
    int p_len = 0;
    always @(negedge clk) begin
        pulse_t pe;
        if (trig_out === 1'b1) begin
            if (!prev_trig) begin
                p_start = cyc;
                p_len = 0;
            end
            p_len++;
        end else if (prev_trig) begin
            n_checks++;
            if (pq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: got start %0d len %0d, expected no pulse", p_start, p_len);
            end else begin
                pe = pq.pop_front();
                if (p_start != pe.start || p_len != pe.len) begin
                    n_fail++;
                    $display("FAIL %s: got start %0d len %0d, expected start %0d len %0d",
                             pe.name, p_start, p_len, pe.start, pe.len);
                end
            end
        end
        prev_trig = (trig_out === 1'b1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reg_wr(input logic [5:0] a, input logic [15:0] bc, input logic [7:0] d);
        reg_address = a; reg_bytecnt = bc; reg_datai = d;
        reg_write = 1'b1; reg_addrvalid = 1'b1;
        @(negedge clk);
        reg_write = 1'b0; reg_addrvalid = 1'b0;
    endtask

    task automatic chk(input int kind, input logic [5:0] a, input logic [15:0] bc,
                       input logic [15:0] exp, input string name);
        reg_address = a; reg_bytecnt = bc; reg_hypaddress = a;
        reg_read = (kind == K_DATA); reg_addrvalid = (kind == K_DATA);
        rq.push_back('{kind, name, exp});
        chk_stb = 1'b1;
        @(negedge clk);
        #1;
        chk_stb = 1'b0; reg_read = 1'b0; reg_addrvalid = 1'b0;
    endtask

    // Input change at this negedge is sampled by the next two edges; trigger follows on the third.
    task automatic push_pulse(input int len, input string name);
        pq.push_back('{cyc + 3, len, name});
    endtask

    task automatic set_stage(input int s, input logic [7:0] m, input logic [7:0] v, input logic [15:0] w);
        reg_wr(A_STG, 16'(4 * s),     m);
        reg_wr(A_STG, 16'(4 * s + 1), v);
        reg_wr(A_STG, 16'(4 * s + 2), w[7:0]);
        reg_wr(A_STG, 16'(4 * s + 3), w[15:8]);
    endtask

    task automatic poll_stage(input logic [2:0] tgt, input int budget, input string name);
        bit ok;
        ok = 1'b0;
        reg_address = A_STS; reg_bytecnt = 16'd0; reg_read = 1'b1; reg_addrvalid = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (reg_datao[2:0] == tgt) begin
                ok = 1'b1;
                break;
            end
        end
        reg_read = 1'b0; reg_addrvalid = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got stage %0d, expected stage %0d within %0d cycles",
                     name, reg_datao[2:0], tgt, budget);
        end
    endtask

    task automatic do_reset();
        trig_in = '0;
        reset_i = 1'b1;
        tick(2);
        reset_i = 1'b0;
        tick(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, expected summary before 2ms");
        $fatal(1);
    end

    initial begin
        // Reset state and register readback
        tick(1);
        do_reset();
        chk(K_TRIG,  A_STS, 0, 16'h0, "reset_trig");
        chk(K_ARMED, A_STS, 0, 16'h0, "reset_armed");
        chk(K_DATA,  A_STS, 0, 16'h00, "reset_status0");
        chk(K_DATA,  A_CFG, 0, 16'h00, "reset_cfg0");
        reg_wr(A_CFG, 0, 8'h31);
        reg_wr(A_CFG, 1, 8'h05);
        reg_wr(A_STG, 4, 8'h03);
        reg_wr(A_STG, 5, 8'h02);
        reg_wr(A_STG, 16, 8'hAA);
        chk(K_DATA,  A_CFG, 0, 16'h31, "rb_cfg0");
        chk(K_DATA,  A_CFG, 1, 16'h05, "rb_cfg1");
        chk(K_DATA,  A_CFG, 2, 16'h00, "rb_cfg2_reserved");
        chk(K_DATA,  A_STG, 4, 16'h03, "rb_s1_mask");
        chk(K_DATA,  A_STG, 5, 16'h02, "rb_s1_value");
        chk(K_DATA,  A_STG, 0, 16'h00, "rb_s0_mask_oob_write");
        chk(K_ARMED, A_STS, 0, 16'h1, "armed_after_enable");
        chk(K_HYP,   A_STG, 0, 16'd16, "hyplen_stage");
        chk(K_HYP,   A_CFG, 0, 16'd4,  "hyplen_cfg");
        chk(K_HYP,   A_STS, 0, 16'd2,  "hyplen_status");
        chk(K_HYP,   6'd10, 0, 16'd0,  "hyplen_foreign");
        chk(K_DATA,  6'd10, 0, 16'h00, "datao_foreign");

        // Two-stage sequence, width 5
        do_reset();
        set_stage(0, 8'h01, 8'h01, 16'd0);
        set_stage(1, 8'h02, 8'h02, 16'd0);
        reg_wr(A_CFG, 1, 8'd5);
        reg_wr(A_CFG, 0, 8'h11);
        tick(4);
        trig_in[0] = 1'b1;
        tick(20);
        trig_in[1] = 1'b1;
        push_pulse(5, "two_stage_pulse");
        tick(15);
        chk(K_DATA,  A_STS, 0, 16'h81, "two_stage_status0");
        chk(K_DATA,  A_STS, 1, 16'h00, "two_stage_abort");
        chk(K_ARMED, A_STS, 0, 16'h0, "two_stage_done_not_armed");

        // A held level must not satisfy two consecutive stages
        do_reset();
        set_stage(0, 8'h01, 8'h01, 16'd0);
        set_stage(1, 8'h01, 8'h01, 16'd0);
        reg_wr(A_CFG, 1, 8'd1);
        reg_wr(A_CFG, 0, 8'h11);
        tick(4);
        trig_in[0] = 1'b1;
        tick(20);
        chk(K_DATA, A_STS, 0, 16'h01, "level_hold_stage1");
        tick(1);
        trig_in[0] = 1'b0;
        tick(1);
        trig_in[0] = 1'b1;
        push_pulse(1, "level_reuse_pulse");
        tick(8);
        chk(K_DATA, A_STS, 0, 16'h81, "level_reuse_status0");

        // Timeout boundary, abort saturation, status clear
        do_reset();
        set_stage(0, 8'h01, 8'h01, 16'd0);
        set_stage(1, 8'h02, 8'h02, 16'd10);
        reg_wr(A_CFG, 1, 8'd1);
        reg_wr(A_CFG, 0, 8'h11);
        tick(4);
        trig_in[0] = 1'b1;
        poll_stage(3'd1, 20, "timeout_enter_s1");
        tick(9);
        chk(K_DATA, A_STS, 0, 16'h01, "timeout_still_s1_at_window");
        chk(K_DATA, A_STS, 0, 16'h00, "timeout_abort_to_s0");
        chk(K_DATA, A_STS, 1, 16'h01, "abort_cnt_one");
        reg_wr(A_STG, 6, 8'd2);
        for (int i = 0; i < 300; i++) begin
            trig_in[0] = 1'b0;
            tick(3);
            trig_in[0] = 1'b1;
            tick(10);
        end
        chk(K_DATA, A_STS, 1, 16'hFF, "abort_cnt_saturated");
        reg_wr(A_STS, 0, 8'h00);
        chk(K_DATA, A_STS, 0, 16'h00, "status_clear_b0");
        chk(K_DATA, A_STS, 1, 16'h00, "status_clear_b1");

        // Match on the timer==window cycle wins over abort
        do_reset();
        set_stage(0, 8'h01, 8'h01, 16'd0);
        set_stage(1, 8'h02, 8'h02, 16'd10);
        reg_wr(A_CFG, 1, 8'd1);
        reg_wr(A_CFG, 0, 8'h11);
        tick(4);
        trig_in[0] = 1'b1;
        poll_stage(3'd1, 20, "tie_enter_s1");
        tick(8);
        trig_in[1] = 1'b1;
        push_pulse(1, "tie_pulse");
        tick(8);
        chk(K_DATA, A_STS, 0, 16'h81, "tie_status0");
        chk(K_DATA, A_STS, 1, 16'h00, "tie_abort_unchanged");

        // Auto-rearm: two sequences, two pulses
        do_reset();
        set_stage(0, 8'h01, 8'h01, 16'd0);
        set_stage(1, 8'h02, 8'h02, 16'd0);
        reg_wr(A_CFG, 1, 8'd1);
        reg_wr(A_CFG, 0, 8'h13);
        tick(4);
        trig_in[0] = 1'b1;
        tick(6);
        trig_in[1] = 1'b1;
        push_pulse(1, "rearm_pulse1");
        tick(6);
        trig_in = '0;
        tick(4);
        trig_in[0] = 1'b1;
        tick(6);
        trig_in[1] = 1'b1;
        push_pulse(1, "rearm_pulse2");
        tick(6);
        chk(K_ARMED, A_STS, 0, 16'h1, "rearm_armed");
        chk(K_DATA,  A_STS, 0, 16'h80, "rearm_status0");

        // Enable clear truncates an 8-cycle pulse after 3 cycles
        reg_wr(A_CFG, 1, 8'd8);
        trig_in = '0;
        tick(4);
        trig_in[0] = 1'b1;
        tick(6);
        trig_in[1] = 1'b1;
        push_pulse(3, "truncated_pulse");
        tick(5);
        reg_wr(A_CFG, 0, 8'h00);
        chk(K_TRIG,  A_STS, 0, 16'h0, "disable_trig_low");
        chk(K_ARMED, A_STS, 0, 16'h0, "disable_not_armed");

        // Reset while armed
        reg_wr(A_CFG, 0, 8'h13);
        tick(3);
        chk(K_ARMED, A_STS, 0, 16'h1, "rearmed_before_reset");
        reset_i = 1'b1;
        tick(1);
        reset_i = 1'b0;
        chk(K_TRIG,  A_STS, 0, 16'h0, "reset_wait_trig");
        chk(K_ARMED, A_STS, 0, 16'h0, "reset_wait_armed");
        chk(K_DATA,  A_STS, 0, 16'h00, "reset_wait_status0");
        chk(K_DATA,  A_CFG, 0, 16'h00, "reset_wait_cfg0");

        tick(12);
        while (pq.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got no pulse, expected start %0d len %0d",
                     pq[0].name, pq[0].start, pq[0].len);
            void'(pq.pop_front());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
